// File: rtl/led_display_ram.sv
// Dual-bank frame buffer for a HUB75-style RGB LED panel, with a built-in fill engine.
// One read returns the top-half and bottom-half pixel of a scan row/column pair.
module led_display_ram #(
  parameter int SYS_CLK_FREQ   = 12_500_000,
  parameter int NUM_ROW_PIXELS = 32,
  parameter int NUM_COL_PIXELS = 64,
  parameter int COLOUR_DEPTH   = 8,
  localparam int PW    = 3 * COLOUR_DEPTH,
  localparam int RW    = $clog2(NUM_ROW_PIXELS),
  localparam int CW    = $clog2(NUM_COL_PIXELS),
  localparam int HR    = NUM_ROW_PIXELS / 2,
  localparam int SW    = $clog2(HR),
  localparam int DEPTH = HR * NUM_COL_PIXELS,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_in,
  input  logic          reset_in,
  input  logic          wr_valid_in,
  output logic          wr_ready_out,
  input  logic [RW-1:0] wr_row_in,
  input  logic [CW-1:0] wr_col_in,
  input  logic [PW-1:0] wr_data_in,
  input  logic          rd_en_in,
  input  logic [SW-1:0] rd_row_in,
  input  logic [CW-1:0] rd_col_in,
  output logic          rd_valid_out,
  output logic [PW-1:0] rd_top_out,
  output logic [PW-1:0] rd_bot_out,
  input  logic          fill_start_in,
  input  logic [PW-1:0] fill_data_in,
  output logic          fill_busy_out,
  output logic          fill_state_out
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  fill_state_t   state;
  logic [AW-1:0] fill_addr;
  logic [PW-1:0] fill_colour;

  logic [PW-1:0] top_mem [DEPTH];
  logic [PW-1:0] bot_mem [DEPTH];

  logic          wr_fire;
  logic          wr_in_range;
  logic          wr_is_bot;
  int            wr_srow;
  logic [AW-1:0] wr_addr;
  logic          fill_we;

  logic          rd_in_range;
  logic [AW-1:0] rd_addr;

  assign fill_state_out = state;

  // Write handshake: a write transfers in any cycle where wr_valid_in && wr_ready_out,
  // and takes effect at that clock edge. wr_ready_out is low only while the fill runs.
  assign wr_fire = wr_valid_in && wr_ready_out;
  assign fill_we = (state == FILL);

  always_comb begin
    wr_in_range = (int'(wr_row_in) < NUM_ROW_PIXELS) && (int'(wr_col_in) < NUM_COL_PIXELS);
    wr_is_bot   = (int'(wr_row_in) >= HR);
    wr_srow     = wr_is_bot ? (int'(wr_row_in) - HR) : int'(wr_row_in);
    wr_addr     = AW'(wr_srow * NUM_COL_PIXELS + int'(wr_col_in));
  end

  always_comb begin
    rd_in_range = (int'(rd_row_in) < HR) && (int'(rd_col_in) < NUM_COL_PIXELS);
    rd_addr     = AW'(int'(rd_row_in) * NUM_COL_PIXELS + int'(rd_col_in));
  end

  // Fill engine: one address per cycle written into both banks, then back to idle.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state         <= IDLE;
      fill_addr     <= '0;
      fill_colour   <= '0;
      fill_busy_out <= 1'b0;
      wr_ready_out  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (fill_start_in) begin
            state         <= FILL;
            fill_colour   <= fill_data_in;
            fill_addr     <= '0;
            fill_busy_out <= 1'b1;
            wr_ready_out  <= 1'b0;
          end
        end
        FILL: begin
          if (fill_addr == LAST_ADDR) begin
            state         <= IDLE;
            fill_busy_out <= 1'b0;
            wr_ready_out  <= 1'b1;
          end else begin
            fill_addr <= fill_addr + 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          fill_busy_out <= 1'b0;
          wr_ready_out  <= 1'b1;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; a reset mid-fill leaves the frame partially filled.
  always_ff @(posedge clk_in) begin
    if (fill_we) begin
      top_mem[fill_addr] <= fill_colour;
      bot_mem[fill_addr] <= fill_colour;
    end else if (wr_fire && wr_in_range) begin
      if (wr_is_bot) begin
        bot_mem[wr_addr] <= wr_data_in;
      end else begin
        top_mem[wr_addr] <= wr_data_in;
      end
    end
  end

  // Read-first: non-blocking memory updates mean a same-edge write is not yet visible here.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      rd_valid_out <= 1'b0;
      rd_top_out   <= '0;
      rd_bot_out   <= '0;
    end else begin
      rd_valid_out <= rd_en_in;
      if (rd_en_in) begin
        if (rd_in_range) begin
          rd_top_out <= top_mem[rd_addr];
          rd_bot_out <= bot_mem[rd_addr];
        end else begin
          rd_top_out <= '0;
          rd_bot_out <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_display_ram.sv
// Scoreboard bench for led_display_ram: model frame in the bench, expected read data
// queued when a read is issued and compared when rd_valid_out appears.
module tb_led_display_ram;

  localparam int PW    = 24;
  localparam int RW    = 5;
  localparam int CW    = 6;
  localparam int SW    = 4;
  localparam int HR    = 16;
  localparam int NCOL  = 64;
  localparam int DEPTH = HR * NCOL;

  logic          clk_in = 1'b0;
  logic          reset_in = 1'b1;
  logic          wr_valid_in = 1'b0;
  logic          wr_ready_out;
  logic [RW-1:0] wr_row_in = '0;
  logic [CW-1:0] wr_col_in = '0;
  logic [PW-1:0] wr_data_in = '0;
  logic          rd_en_in = 1'b0;
  logic [SW-1:0] rd_row_in = '0;
  logic [CW-1:0] rd_col_in = '0;
  logic          rd_valid_out;
  logic [PW-1:0] rd_top_out;
  logic [PW-1:0] rd_bot_out;
  logic          fill_start_in = 1'b0;
  logic [PW-1:0] fill_data_in = '0;
  logic          fill_busy_out;
  logic          fill_state_out;

  led_display_ram dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .wr_valid_in    (wr_valid_in),
    .wr_ready_out   (wr_ready_out),
    .wr_row_in      (wr_row_in),
    .wr_col_in      (wr_col_in),
    .wr_data_in     (wr_data_in),
    .rd_en_in       (rd_en_in),
    .rd_row_in      (rd_row_in),
    .rd_col_in      (rd_col_in),
    .rd_valid_out   (rd_valid_out),
    .rd_top_out     (rd_top_out),
    .rd_bot_out     (rd_bot_out),
    .fill_start_in  (fill_start_in),
    .fill_data_in   (fill_data_in),
    .fill_busy_out  (fill_busy_out),
    .fill_state_out (fill_state_out)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;
  bit mon_on = 1'b0;

  logic [2*PW-1:0] exp_q[$];
  logic [PW-1:0]   m_top [DEPTH];
  logic [PW-1:0]   m_bot [DEPTH];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // One bus cycle: optional write (pixel row/col) and optional read (scan row/col).
  task automatic drive_cycle(input bit we, input int row, input int col, input logic [PW-1:0] d,
                             input bit re, input int srow, input int rcol);
    int a;
    wr_valid_in = we;
    wr_row_in   = RW'(row);
    wr_col_in   = CW'(col);
    wr_data_in  = d;
    rd_en_in    = re;
    rd_row_in   = SW'(srow);
    rd_col_in   = CW'(rcol);
    if (re) begin
      a = srow * NCOL + rcol;
      exp_q.push_back({m_top[a], m_bot[a]});
    end
    if (we) begin
      a = (row % HR) * NCOL + col;
      if (row < HR) m_top[a] = d;
      else m_bot[a] = d;
    end
    tick();
    wr_valid_in = 1'b0;
    rd_en_in    = 1'b0;
  endtask

  task automatic read_addr(input int a);
    drive_cycle(1'b0, 0, 0, '0, 1'b1, a / NCOL, a % NCOL);
  endtask

  // Starts a fill, tries a blocked write part way through, optionally resets at stop_at.
  task automatic do_fill(input logic [PW-1:0] c, input int stop_at, output int busy_cycles);
    int n;
    n = 0;
    fill_start_in = 1'b1;
    fill_data_in  = c;
    tick();
    fill_start_in = 1'b0;
    fill_data_in  = ~c;
    for (int k = 0; k < 2000; k++) begin
      if (!fill_busy_out) break;
      n++;
      if (n == 100) begin
        check_eq("busy_wr_ready", wr_ready_out, 1'b0);
        wr_valid_in = 1'b1;
        wr_row_in   = RW'(31);
        wr_col_in   = CW'(63);
        wr_data_in  = 24'h000055;
      end else begin
        wr_valid_in = 1'b0;
      end
      if (stop_at != 0 && n == stop_at) reset_in = 1'b1;
      tick();
      if (reset_in) begin
        reset_in = 1'b0;
        break;
      end
    end
    wr_valid_in = 1'b0;
    busy_cycles = n;
  endtask

  // Monitor: rd_valid must follow rd_en by one cycle; valid data pops the scoreboard.
  always @(posedge clk_in) begin
    logic en_s;
    logic rst_s;
    logic [2*PW-1:0] e;
    en_s  = rd_en_in;
    rst_s = reset_in;
    #1;
    if (mon_on && !rst_s) begin
      check_eq("rd_valid", rd_valid_out, en_s);
      if (rd_valid_out && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("rd_data", {rd_top_out, rd_bot_out}, e);
      end
    end
  end

  initial begin
    int n;
    // reset state
    reset_in = 1'b1;
    tick();
    tick();
    check_eq("rst_wr_ready", wr_ready_out, 1'b1);
    check_eq("rst_rd_valid", rd_valid_out, 1'b0);
    check_eq("rst_rd_data", {rd_top_out, rd_bot_out}, '0);
    check_eq("rst_busy", fill_busy_out, 1'b0);
    check_eq("rst_state", fill_state_out, 1'b0);
    reset_in = 1'b0;
    mon_on   = 1'b1;
    tick();

    // 1: clear frame, busy exactly one full frame of cycles
    do_fill(24'h000000, 0, n);
    check_eq("fill0_busy_cycles", n, 1024);
    check_eq("fill0_ready_after", wr_ready_out, 1'b1);
    for (int a = 0; a < DEPTH; a++) begin
      m_top[a] = '0;
      m_bot[a] = '0;
    end
    for (int a = 0; a < DEPTH; a++) read_addr(a);

    // 2: top/bottom pair at scan row 0
    drive_cycle(1'b1, 0, 0, 24'hFF0000, 1'b0, 0, 0);
    drive_cycle(1'b1, 16, 0, 24'h00FF00, 1'b0, 0, 0);
    read_addr(0);
    tick();
    check_eq("pair_top", rd_top_out, 24'hFF0000);

    // 3: last pixel lands in bottom bank
    drive_cycle(1'b1, 31, 63, 24'h0000FF, 1'b0, 0, 0);
    drive_cycle(1'b0, 0, 0, '0, 1'b1, 15, 63);
    tick();
    check_eq("last_bot", rd_bot_out, 24'h0000FF);
    check_eq("last_top", rd_top_out, 24'h000000);

    // 4: random full frame, sweep with random idle gaps
    for (int r = 0; r < 2 * HR; r++)
      for (int c = 0; c < NCOL; c++)
        drive_cycle(1'b1, r, c, PW'($urandom), 1'b0, 0, 0);
    for (int a = 0; a < DEPTH; a++) begin
      if ($urandom_range(0, 3) == 0) tick();
      read_addr(a);
    end

    // 5: same-cycle read/write returns old data
    drive_cycle(1'b1, 5, 10, 24'h123456, 1'b0, 0, 0);
    drive_cycle(1'b1, 5, 10, 24'hABCDEF, 1'b1, 5, 10);
    check_eq("rfirst_old", rd_top_out, 24'h123456);
    read_addr(5 * NCOL + 10);
    check_eq("rfirst_new", rd_top_out, 24'hABCDEF);

    // 6: fill interrupted by reset at cycle 500; blocked write must not land
    do_fill(24'h0F0F0F, 500, n);
    check_eq("abort_cycles", n, 500);
    check_eq("abort_busy", fill_busy_out, 1'b0);
    check_eq("abort_ready", wr_ready_out, 1'b1);
    check_eq("abort_rd_valid", rd_valid_out, 1'b0);
    for (int a = 0; a < 500; a++) begin
      m_top[a] = 24'h0F0F0F;
      m_bot[a] = 24'h0F0F0F;
    end
    for (int a = 0; a < DEPTH; a++) begin
      if (a != 500) read_addr(a);
    end

    tick();
    tick();
    check_eq("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
